// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared FSM states and limits for the bit-serial adder controller
package serial_add_pkg;

  localparam int SERIAL_ADD_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell shared across all operand bits
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial WIDTH-bit add controller; SERIAL_ADD_SUB_EN adds subtract mode
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub_in,
`endif
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    bit_cnt;
  logic             accept;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Subtraction is A + ~B + 1, so only the loaded operand and carry differ.
  always_comb begin
    b_load = b_in;
    c_load = cin_in;
`ifdef SERIAL_ADD_SUB_EN
    if (sub_in) begin
      b_load = ~b_in;
      c_load = 1'b1;
    end
`endif
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
    end else if (accept) begin
      a_sr    <= a_in;
      b_sr    <= b_load;
      carry   <= c_load;
      bit_cnt <= '0;
    end else if (state == RUN) begin
      // Sum enters at the MSB so after WIDTH shifts bit 0 lands at res_sr[0].
      res_sr  <= WIDTH'({fa_sum, res_sr} >> 1);
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      carry   <= fa_cout;
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  assign result = res_sr;
  assign cout   = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed and random checks of serial_add_ctrl at WIDTH=8
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       cin_in;
  logic       sub_in;
  logic [7:0] result;
  logic       cout;
  logic       done_valid;
  logic       done_ready;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .cin_in      (cin_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub_in      (sub_in),
`endif
    .result      (result),
    .cout        (cout),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + 9'd1;
    return {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    a_in        = a;
    b_in        = b;
    cin_in      = c;
    sub_in      = s;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!done_valid && n < 40) begin
      tick();
      n++;
    end
    if (!done_valid) chk({tag, "_timeout"}, done_valid, 1);
  endtask

  task automatic retire();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
  endtask

  logic [8:0] q[$];
  logic [8:0] exp9;
  int n;
  int accepted;
  int retired;
  int pulses;
  logic acc;
  logic ret;
  logic rs;

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; a_in = '0; b_in = '0;
    cin_in = 1'b0; sub_in = 1'b0; done_ready = 1'b0;
    tick(); tick();
    chk("rst_start_ready", start_ready, 1);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 8'h00);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    tick();

    // FF + 01: wrap with carry, 8-cycle latency
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    chk("t1_busy", busy, 1);
    chk("t1_start_ready", start_ready, 0);
    wait_done("t1", n);
    chk("t1_latency", n, 8);
    chk("t1_result", result, 8'h00);
    chk("t1_cout", cout, 1);
    retire();
    chk("t1_idle_ready", start_ready, 1);
    chk("t1_idle_dv", done_valid, 0);

    // 5A + 33 + 1, operands disturbed after acceptance
    issue(8'h5A, 8'h33, 1'b1, 1'b0);
    a_in = 8'hFF; b_in = 8'hFF; cin_in = 1'b0;
    wait_done("t2", n);
    chk("t2_result", result, 8'h8E);
    chk("t2_cout", cout, 0);
    retire();

    // DONE held with start_valid high throughout
    a_in = 8'h12; b_in = 8'h34; cin_in = 1'b0; start_valid = 1'b1;
    tick();
    a_in = 8'h77; b_in = 8'h11;
    wait_done("t3", n);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_result", result, 8'h46);
      chk("t3_hold_cout", cout, 0);
      chk("t3_hold_sready", start_ready, 0);
      chk("t3_hold_dv", done_valid, 1);
    end
    retire();
    chk("t3_retired_busy", busy, 0);
    chk("t3_retired_sready", start_ready, 1);
    tick();
    start_valid = 1'b0;
    chk("t3_next_busy", busy, 1);
    wait_done("t3b", n);
    chk("t3b_result", result, 8'h88);
    chk("t3b_cout", cout, 0);
    retire();

    // reset during bit 3 of AA + 55
    issue(8'hAA, 8'h55, 1'b0, 1'b0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("t4_busy", busy, 0);
    chk("t4_result", result, 8'h00);
    chk("t4_cout", cout, 0);
    chk("t4_dv", done_valid, 0);
    chk("t4_sready", start_ready, 1);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_valid) pulses++;
    end
    chk("t4_no_done", pulses, 0);
    issue(8'h01, 8'h01, 1'b0, 1'b0);
    wait_done("t4b", n);
    chk("t4b_result", result, 8'h02);
    chk("t4b_cout", cout, 0);
    retire();

`ifdef SERIAL_ADD_SUB_EN
    issue(8'h10, 8'h01, 1'b0, 1'b1);
    wait_done("t5a", n);
    chk("t5a_result", result, 8'h0F);
    chk("t5a_cout", cout, 1);
    retire();
    issue(8'h00, 8'h01, 1'b1, 1'b1);
    wait_done("t5b", n);
    chk("t5b_result", result, 8'hFF);
    chk("t5b_cout", cout, 0);
    retire();
`endif

    // random back-to-back traffic against the reference model
    accepted = 0;
    retired  = 0;
    rs = 1'b0;
    a_in = 8'($urandom); b_in = 8'($urandom); cin_in = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
    rs = 1'($urandom);
`endif
    sub_in = rs;
    start_valid = 1'b1;
    done_ready = 1'($urandom);
    for (int cyc = 0; cyc < 30000 && retired < 1000; cyc++) begin
      acc = start_valid && start_ready;
      ret = done_valid && done_ready;
      if (ret) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_done", 1, 0);
        end else begin
          exp9 = q.pop_front();
          chk("rand_sum", {cout, result}, exp9);
        end
        retired++;
      end
      if (acc) begin
        q.push_back(model(a_in, b_in, cin_in, rs));
        accepted++;
      end
      tick();
      if (acc) begin
        a_in = 8'($urandom); b_in = 8'($urandom); cin_in = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
        rs = 1'($urandom);
`endif
        sub_in = rs;
        if (accepted == 1000) start_valid = 1'b0;
      end
      done_ready = 1'($urandom);
    end
    chk("rand_accepted", accepted, 1000);
    chk("rand_retired", retired, accepted);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
